// File: rtl/vmem_slice_be_pkg.sv
// Shared constants and sizing helpers for the byte-enable vector-memory slice.
package vmem_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned BE_W       = DEF_DATA_W / 8;

  // Read latency in cycles: one for the RAM read, one more with the output register.
  function automatic int unsigned lat(input int unsigned out_reg);
    return 1 + ((out_reg != 0) ? 1 : 0);
  endfunction

  // Response queue depth: enough to absorb every read in flight plus one.
  function automatic int unsigned qdepth(input int unsigned out_reg);
    return lat(out_reg) + 1;
  endfunction

  // Number of byte lanes in a data word.
  function automatic int unsigned be_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/vmem_resp_q.sv
// Small show-ahead FIFO holding {addr, data} read responses for one port.
module vmem_resp_q #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_data,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push_ok;
  logic             w_pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & (r_cnt != '0);
  assign o_full    = (r_cnt == CNT_W'(DEPTH));
  assign o_count   = r_cnt;
  assign o_data    = r_mem[r_rp];

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wp] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) r_wp <= ptr_inc(r_wp);
      if (w_pop_ok)  r_rp <= ptr_inc(r_rp);
      r_cnt <= r_cnt + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
    end
  end

endmodule

// File: rtl/vmem_slice_be.sv
// True dual-port RAM bank with byte enables, configurable read latency and
// per-port lossless response queues.
module vmem_slice_be
  import vmem_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned OUT_REG = 0,
  parameter string       MEMINIT = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     t0_addr,
  input  logic [DATA_W-1:0]     t0_data,
  input  logic [DATA_W/8-1:0]   t0_be,
  input  logic                  t0_we,
  input  logic                  t0_valid,
  output logic                  t0_ready,
  output logic [ADDR_W-1:0]     i0_addr,
  output logic [DATA_W-1:0]     i0_data,
  output logic                  i0_valid,
  input  logic                  i0_ready,
  input  logic [ADDR_W-1:0]     t1_addr,
  input  logic [DATA_W-1:0]     t1_data,
  input  logic [DATA_W/8-1:0]   t1_be,
  input  logic                  t1_we,
  input  logic                  t1_valid,
  output logic                  t1_ready,
  output logic [ADDR_W-1:0]     i1_addr,
  output logic [DATA_W-1:0]     i1_data,
  output logic                  i1_valid,
  input  logic                  i1_ready
);

  localparam int unsigned BEW   = be_w(DATA_W);
  localparam int unsigned Q     = qdepth(OUT_REG);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(Q + 1);
  localparam int unsigned QW    = ADDR_W + DATA_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_req_addr  [2];
  logic [DATA_W-1:0] w_req_data  [2];
  logic [BEW-1:0]    w_req_be    [2];
  logic              w_req_we    [2];
  logic              w_req_valid [2];
  logic              w_req_ready [2];
  logic              w_acc       [2];
  logic              w_in_range  [2];
  logic [IDX_W-1:0]  w_idx       [2];
  logic [ADDR_W-1:0] w_rsp_addr  [2];
  logic [DATA_W-1:0] w_rsp_data  [2];
  logic              w_rsp_valid [2];
  logic              w_rsp_ready [2];

  assign w_req_addr[0]  = t0_addr;
  assign w_req_data[0]  = t0_data;
  assign w_req_be[0]    = t0_be;
  assign w_req_we[0]    = t0_we;
  assign w_req_valid[0] = t0_valid;
  assign w_rsp_ready[0] = i0_ready;
  assign w_req_addr[1]  = t1_addr;
  assign w_req_data[1]  = t1_data;
  assign w_req_be[1]    = t1_be;
  assign w_req_we[1]    = t1_we;
  assign w_req_valid[1] = t1_valid;
  assign w_rsp_ready[1] = i1_ready;

  assign t0_ready = w_req_ready[0];
  assign i0_addr  = w_rsp_addr[0];
  assign i0_data  = w_rsp_data[0];
  assign i0_valid = w_rsp_valid[0];
  assign t1_ready = w_req_ready[1];
  assign i1_addr  = w_rsp_addr[1];
  assign i1_data  = w_rsp_data[1];
  assign i1_valid = w_rsp_valid[1];

  // Byte-lane writes; port 0 is applied last so it owns lanes both ports enable.
  always_ff @(posedge clk) begin
    for (int p = 1; p >= 0; p--) begin
      if (w_acc[p] && w_req_we[p] && w_in_range[p]) begin
        for (int k = 0; k < BEW; k++) begin
          if (w_req_be[p][k]) begin
            r_mem[w_idx[p]][8*k +: 8] <= w_req_data[p][8*k +: 8];
          end
        end
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic              r_s1_v;
    logic [ADDR_W-1:0] r_s1_a;
    logic [DATA_W-1:0] r_s1_d;
    logic              r_s1_z;
    logic [CNT_W-1:0]  r_out;
    logic              w_p_v;
    logic [ADDR_W-1:0] w_p_a;
    logic [DATA_W-1:0] w_p_d;
    logic [DATA_W-1:0] w_s1_d;
    logic              w_rd_acc;
    logic              w_rsp_fire;
    logic              w_q_empty;
    logic              w_q_full;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_q_cnt;
    logic [QW-1:0]     w_q_head;

    assign w_in_range[p] = {1'b0, w_req_addr[p]} < (ADDR_W + 1)'(DEPTH);
    assign w_idx[p]      = w_req_addr[p][IDX_W-1:0];
    assign w_acc[p]      = w_req_valid[p] & w_req_ready[p];
    assign w_rd_acc      = w_acc[p] & ~w_req_we[p];
    assign w_s1_d        = r_s1_z ? '0 : r_s1_d;

    // Registered RAM read (read-first against the other port's write) plus zero-fill flag.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_s1_v <= 1'b0;
        r_s1_a <= '0;
        r_s1_d <= '0;
        r_s1_z <= 1'b0;
      end else begin
        r_s1_v <= w_rd_acc;
        if (w_rd_acc) begin
          r_s1_a <= w_req_addr[p];
          r_s1_d <= r_mem[w_idx[p]];
          r_s1_z <= ~w_in_range[p];
        end
      end
    end

    if (OUT_REG != 0) begin : g_oreg
      logic              r_s2_v;
      logic [ADDR_W-1:0] r_s2_a;
      logic [DATA_W-1:0] r_s2_d;

      // Optional output stage adding one cycle of read latency.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_s2_v <= 1'b0;
          r_s2_a <= '0;
          r_s2_d <= '0;
        end else begin
          r_s2_v <= r_s1_v;
          if (r_s1_v) begin
            r_s2_a <= r_s1_a;
            r_s2_d <= w_s1_d;
          end
        end
      end

      assign w_p_v = r_s2_v;
      assign w_p_a = r_s2_a;
      assign w_p_d = r_s2_d;
    end else begin : g_noreg
      assign w_p_v = r_s1_v;
      assign w_p_a = r_s1_a;
      assign w_p_d = w_s1_d;
    end

    // Pipeline output bypasses the queue when it is empty; otherwise it queues behind older data.
    assign w_q_empty        = (w_q_cnt == '0);
    assign w_rsp_valid[p]   = ~w_q_empty | w_p_v;
    assign w_rsp_addr[p]    = w_q_empty ? w_p_a : w_q_head[QW-1 -: ADDR_W];
    assign w_rsp_data[p]    = w_q_empty ? w_p_d : w_q_head[DATA_W-1:0];
    assign w_rsp_fire       = w_rsp_valid[p] & w_rsp_ready[p];
    assign w_pop            = ~w_q_empty & w_rsp_ready[p];
    assign w_push           = w_p_v & ~(w_q_empty & w_rsp_ready[p]) & ~w_q_full;
    assign w_req_ready[p]   = ~reset & ((r_out < CNT_W'(Q)) | w_rsp_fire);

    // Reads accepted but not yet consumed; caps acceptance at the queue depth.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_out <= '0;
      end else begin
        r_out <= r_out + CNT_W'(w_rd_acc) - CNT_W'(w_rsp_fire);
      end
    end

    vmem_resp_q #(
      .W     (QW),
      .DEPTH (Q)
    ) u_resp_q (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  ({w_p_a, w_p_d}),
      .i_pop   (w_pop),
      .o_data  (w_q_head),
      .o_count (w_q_cnt),
      .o_full  (w_q_full)
    );
  end

endmodule
